// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b single-port memory arbiter.
// The controller FSM states, access owner, latency default and the saturating helper live here.
package lc3b_mem_pkg;

  localparam int WORD_W           = 16;
  localparam int MEM_LATENCY_DEF  = 5;
  localparam int MAX_D_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INSN = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // Saturating 4-bit increment; never exceeds lim.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    logic [3:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lc3b_mem_lat_counter.sv
// Loadable 4-bit down-counter with a zero flag, used to time the memory access window.
// Load wins over decrement, and a decrement at zero holds at zero.
module lc3b_mem_lat_counter
  import lc3b_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: load, decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Single-port memory arbiter for the LC-3b fetch (read-only) and MEM (read/write) ports.
// Data has priority over instruction fetch, bounded by a consecutive-data-grant streak limit.
module lc3b_mem_arbiter
  import lc3b_mem_pkg::*;
#(
  parameter int MEM_LATENCY  = MEM_LATENCY_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_r,
  input  logic              d_req,
  input  logic [WORD_W-1:0] d_addr,
  input  logic              d_we_lo,
  input  logic              d_we_hi,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_r,
  output logic              m_en,
  output logic [WORD_W-1:0] m_addr,
  output logic              m_we_lo,
  output logic              m_we_hi,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata
);

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_e            state_q,   state_d;
  owner_e            owner_q,   owner_d;
  logic [3:0]        streak_q,  streak_d;
  logic              m_en_q,    m_en_d;
  logic [WORD_W-1:0] m_addr_q,  m_addr_d;
  logic              m_we_lo_q, m_we_lo_d;
  logic              m_we_hi_q, m_we_hi_d;
  logic [WORD_W-1:0] m_wdata_q, m_wdata_d;
  logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_r_q,     i_r_d;
  logic              d_r_q,     d_r_d;

  logic lat_load_s;
  logic lat_dec_s;
  logic lat_zero_s;
  logic grant_data_s;

  lc3b_mem_lat_counter u_lat (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (lat_load_s),
    .dec_i      (lat_dec_s),
    .load_val_i (LAT_LOAD),
    .zero_o     (lat_zero_s)
  );

  // Arbitration, access sequencing and ready/capture decisions.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    m_en_d       = m_en_q;
    m_addr_d     = m_addr_q;
    m_we_lo_d    = m_we_lo_q;
    m_we_hi_d    = m_we_hi_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_r_d        = 1'b0;
    d_r_d        = 1'b0;
    lat_load_s   = 1'b0;
    lat_dec_s    = 1'b0;
    grant_data_s = d_req && !(i_req && (streak_q == STREAK_MAX));

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d    = ST_BUSY;
          lat_load_s = 1'b1;
          m_en_d     = 1'b1;
          if (grant_data_s) begin
            owner_d   = OWN_DATA;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_we_lo_d = d_we_lo;
            m_we_hi_d = d_we_hi;
            if (i_req) begin
              streak_d = sat_inc(streak_q, STREAK_MAX);
            end else begin
              streak_d = 4'd0;
            end
          end else begin
            owner_d   = OWN_INSN;
            m_addr_d  = i_addr;
            m_wdata_d = 16'h0000;
            m_we_lo_d = 1'b0;
            m_we_hi_d = 1'b0;
            streak_d  = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (lat_zero_s) begin
          state_d   = ST_DONE;
          m_en_d    = 1'b0;
          m_we_lo_d = 1'b0;
          m_we_hi_d = 1'b0;
          // A requester that withdrew mid-access gets neither a pulse nor new data.
          if (owner_q == OWN_INSN) begin
            if (i_req) begin
              i_r_d     = 1'b1;
              i_rdata_d = m_rdata;
            end else begin
              i_r_d = 1'b0;
            end
          end else begin
            if (d_req) begin
              d_r_d = 1'b1;
              if (!(m_we_lo_q || m_we_hi_q)) begin
                d_rdata_d = m_rdata;
              end else begin
                d_rdata_d = d_rdata_q;
              end
            end else begin
              d_r_d = 1'b0;
            end
          end
        end else begin
          lat_dec_s = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_INSN;
      streak_q  <= 4'd0;
      m_en_q    <= 1'b0;
      m_addr_q  <= 16'h0000;
      m_we_lo_q <= 1'b0;
      m_we_hi_q <= 1'b0;
      m_wdata_q <= 16'h0000;
      i_rdata_q <= 16'h0000;
      d_rdata_q <= 16'h0000;
      i_r_q     <= 1'b0;
      d_r_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      m_en_q    <= m_en_d;
      m_addr_q  <= m_addr_d;
      m_we_lo_q <= m_we_lo_d;
      m_we_hi_q <= m_we_hi_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_r_q     <= i_r_d;
      d_r_q     <= d_r_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_addr  = m_addr_q;
  assign m_we_lo = m_we_lo_q;
  assign m_we_hi = m_we_hi_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_r     = i_r_q;
  assign d_r     = d_r_q;

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
Single-port memory controller/arbiter shared by two requesters: the fetch stage (instruction port, read-only) and the MEM stage (data port, read/write with byte enables).
- Serialises accesses to one backing memory with a fixed multi-cycle latency.
- Returns per-port ready pulses (the imem_r / dmem_r equivalents).
- Applies data-over-instruction priority with a starvation bound.
- Sits between the pipeline stage latches and the Memory block.

Parameters:
MEM_LATENCY, 5, cycles the memory address/controls must be held before read data is valid (legal range 1..15)
MAX_D_STREAK, 4, consecutive data grants allowed while i_req is pending before the instruction port is forced next (legal range 1..15)

Ports:
clk  in  1  system clock (pipeline clock domain)
rst_n  in  1  asynchronous, active-low reset
i_req  in  1  instruction read request, level, held until i_r
i_addr  in  16  instruction word address (PC)
i_rdata  out  16  captured instruction word
i_r  out  1  instruction ready, one-cycle pulse
d_req  in  1  data request, level, held until d_r
d_addr  in  16  data address
d_we_lo  in  1  write low byte
d_we_hi  in  1  write high byte (both low = read)
d_wdata  in  16  write data
d_rdata  out  16  captured read data
d_r  out  1  data ready, one-cycle pulse (reads and writes)
m_en  out  1  memory enable, high only while an access is in flight
m_addr  out  16  memory address
m_we_lo  out  1  memory low-byte write enable
m_we_hi  out  1  memory high-byte write enable
m_wdata  out  16  memory write data
m_rdata  in  16  memory read data, valid on the last BUSY cycle

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, any time, including mid-access):
  - state=IDLE; i_r=d_r=0; i_rdata=d_rdata=16'h0000.
  - m_en=m_we_lo=m_we_hi=0; m_addr=m_wdata=0.
  - lat_cnt=0; streak=0. An in-flight access is dropped and no ready pulse is issued.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE: at edge E0, if any request is high, grant and go to BUSY.
  - Latch addr, wdata and byte enables into the m_* registers; latch owner (INSN/DATA); lat_cnt=MEM_LATENCY-1.
  - Arbitration: d_req wins unless i_req=1 and streak==MAX_D_STREAK, in which case i_req wins.
  - streak: increments on a data grant while i_req=1 (saturating); clears on any instruction grant; clears on a data grant with i_req=0.
- BUSY: m_en=1; m_* held stable for exactly MEM_LATENCY cycles.
  - lat_cnt decrements each edge.
  - At the edge where lat_cnt==0 (edge E_L, L=MEM_LATENCY): capture m_rdata into the owner's rdata register (reads only; a write leaves d_rdata unchanged); clear m_en and m_we_*; go to DONE.
- DONE: the owner's ready pulse is high for this one cycle.
  - Next edge returns to IDLE unconditionally; requests are not sampled in DONE.
  - This lets the requester drop req after seeing ready without a double grant.
- Latency: request high at E0 gives ready high during the cycle after E_L. Minimum back-to-back spacing is L+2 edges per access.
- Request dropped mid-access (e.g. fetch redirect):
  - The access still runs to completion.
  - The ready pulse is suppressed if the owner's req is low at E_L, and rdata is not updated.
- Simultaneous i_req and d_req in IDLE: resolved by the priority rule above; the loser stays pending and is considered again at the next IDLE.
- Request arriving while BUSY/DONE: waits; it is never lost.
- d_we_lo/d_we_hi sampled high with d_req: write. m_we_* mirrors the latched enables for all BUSY cycles.
- lat_cnt and streak are 4 bits and do not wrap; streak saturates at MAX_D_STREAK.

Decomposition:
- Package lc3b_mem_pkg holds:
  - FSM state enum (IDLE/BUSY/DONE);
  - owner enum (OWN_INSN/OWN_DATA);
  - MEM_LATENCY default;
  - word width 16.
- One sub-module: lc3b_mem_lat_counter, a loadable down-counter with a zero flag and async active-low reset.

Test Plan:
- Reset, then i_req=1, i_addr=16'h3000, m_rdata=16'h1234 → m_en high 5 cycles with m_addr=3000; i_r pulses exactly once, 6 cycles after the request edge; i_rdata=1234.
- i_req and d_req raised in the same cycle (d read 16'h4000) → data granted first; instruction granted at the next IDLE; i_r arrives 7 cycles after d_r.
- d_req held continuously (5 back-to-back reads) with i_req held → 4 data grants, then an instruction grant, then data resumes; streak reset is observed.
- Data write, d_addr=16'h5001, d_we_hi=1, d_we_lo=0, d_wdata=16'hAB00 → m_we_hi=1 and m_we_lo=0 for 5 cycles; d_r pulses; d_rdata unchanged.
- i_req dropped on cycle 2 of BUSY → m_en still runs 5 cycles; no i_r pulse; i_rdata keeps its old value; the next request is granted normally.
- rst_n asserted on cycle 3 of BUSY → all outputs 0 immediately (asynchronously); after release, IDLE with no ready pulse.
